// File: rtl/uart_tx_if.sv
// Byte-request / serial-line bundle between a byte source and the UART transmitter.
interface uart_tx_if;
    logic [2:0] Baud_Set;
    logic [7:0] Data_Byte;
    logic       Send_En;
    logic       Rs232_Tx;
    logic       Tx_Busy;
    logic       Tx_Done;

    modport master (output Baud_Set, Data_Byte, Send_En, input Rs232_Tx, Tx_Busy, Tx_Done);
    modport slave  (input Baud_Set, Data_Byte, Send_En, output Rs232_Tx, Tx_Busy, Tx_Done);
endinterface

// File: rtl/uart_tx.sv
// RS-232 transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Baud_Set encoding matches uart_rx so both sides can share one rate select.
module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input logic     Clk,
    input logic     Rst,
    uart_tx_if.slave bus
);
    localparam int CW = $clog2(CLK_FREQ / 9600 + 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    function automatic logic [CW-1:0] div_of(input logic [2:0] sel);
        case (sel)
            3'd1:    return CW'(CLK_FREQ / 19200);
            3'd2:    return CW'(CLK_FREQ / 38400);
            3'd3:    return CW'(CLK_FREQ / 57600);
            3'd4:    return CW'(CLK_FREQ / 115200);
            default: return CW'(CLK_FREQ / 9600);
        endcase
    endfunction

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, div_r;
    logic [2:0]    bit_idx, bit_n;
    logic          stop_idx, stop_n;
    logic [7:0]    data_r;
    logic          par_r;
    logic          accept, wrap;
    logic          tx_r, busy_r, done_r;
    logic          tx_n, busy_n, done_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        stop_n  = stop_idx;
        accept  = 1'b0;
        wrap    = (cnt == div_r - 1'b1);
        case (state)
            IDLE: begin
                cnt_n  = '0;
                accept = bus.Send_En;
            end
            START: if (wrap) begin
                state_n = DATA;
                cnt_n   = '0;
                bit_n   = '0;
            end
            DATA: if (wrap) begin
                cnt_n = '0;
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
                    state_n = (PARITY != 0) ? PAR : STOP;
                    stop_n  = 1'b0;
                end
            end
            PAR: if (wrap) begin
                state_n = STOP;
                cnt_n   = '0;
                stop_n  = 1'b0;
            end
            STOP: if (wrap) begin
                cnt_n  = '0;
                stop_n = stop_idx + 1'b1;
                if (stop_idx == LAST_STOP) begin
                    state_n = IDLE;
                    // a request in the Tx_Done cycle chains with no idle gap
                    accept  = bus.Send_En;
                end
            end
            default: state_n = IDLE;
        endcase
        if (accept) begin
            state_n = START;
            cnt_n   = '0;
        end

        // outputs are registered from next-state so Tx_Done lands on the last stop clock
        done_n = (state_n == STOP) && (cnt_n == div_r - 1'b1) && (stop_n == LAST_STOP);
        busy_n = (state_n != IDLE) && !done_n;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_r[bit_n];
            PAR:     tx_n = par_r;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            data_r   <= '0;
            par_r    <= 1'b0;
            div_r    <= '0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
            if (accept) begin
                data_r <= bus.Data_Byte;
                div_r  <= div_of(bus.Baud_Set);
                par_r  <= (PARITY == 1) ? ~^bus.Data_Byte : ^bus.Data_Byte;
            end
            tx_r   <= tx_n;
            busy_r <= busy_n;
            done_r <= done_n;
        end
    end

    assign bus.Rs232_Tx = tx_r;
    assign bus.Tx_Busy  = busy_r;
    assign bus.Tx_Done  = done_r;
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus threads queue expected frames, per-DUT
// monitors decode the serial line at mid-bit and check frame timing.
module tb_uart_tx;
    typedef struct {
        logic [11:0] bits;   // frame bits in line order, bit 0 = start bit
        int          nbits;
        int          div;
    } exp_t;

    logic       clk = 1'b0;
    logic [3:0] rst = 4'hF;
    logic [3:0] en  = 4'h0;
    logic [7:0] dat [4];
    logic [2:0] bd  [4];
    logic [3:0] tx_w, busy_w, done_w;
    logic [3:0] mon_en = 4'hF;
    bit         stop_all = 1'b0;
    longint     cyc = 0;
    int         n_cmp = 0, n_bad = 0;
    exp_t       q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_if if0();
    uart_tx_if if1();
    uart_tx_if if2();
    uart_tx_if if3();

    uart_tx #(.CLK_FREQ(50_000_000), .PARITY(0), .STOP_BITS(1)) u0 (.Clk(clk), .Rst(rst[0]), .bus(if0.slave));
    uart_tx #(.CLK_FREQ(50_000_000), .PARITY(1), .STOP_BITS(1)) u1 (.Clk(clk), .Rst(rst[1]), .bus(if1.slave));
    uart_tx #(.CLK_FREQ(50_000_000), .PARITY(2), .STOP_BITS(2)) u2 (.Clk(clk), .Rst(rst[2]), .bus(if2.slave));
    uart_tx #(.CLK_FREQ(960_000),    .PARITY(0), .STOP_BITS(1)) u3 (.Clk(clk), .Rst(rst[3]), .bus(if3.slave));

    assign if0.Send_En = en[0]; assign if0.Data_Byte = dat[0]; assign if0.Baud_Set = bd[0];
    assign if1.Send_En = en[1]; assign if1.Data_Byte = dat[1]; assign if1.Baud_Set = bd[1];
    assign if2.Send_En = en[2]; assign if2.Data_Byte = dat[2]; assign if2.Baud_Set = bd[2];
    assign if3.Send_En = en[3]; assign if3.Data_Byte = dat[3]; assign if3.Baud_Set = bd[3];
    assign tx_w   = {if3.Rs232_Tx, if2.Rs232_Tx, if1.Rs232_Tx, if0.Rs232_Tx};
    assign busy_w = {if3.Tx_Busy,  if2.Tx_Busy,  if1.Tx_Busy,  if0.Tx_Busy};
    assign done_w = {if3.Tx_Done,  if2.Tx_Done,  if1.Tx_Done,  if0.Tx_Done};

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic pop(input int i, output exp_t e, output bit ok);
        ok = (qsize(i) != 0);
        e  = '{12'h0, 0, 1};
        if (ok) case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic [2:0] b, output longint acc);
        @(negedge clk);
        en[i] = 1'b1; dat[i] = d; bd[i] = b;
        acc = cyc;
        @(negedge clk);
        en[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int bound, input string nm, output longint t);
        bit ok = 1'b0;
        t = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done_w[i]) begin ok = 1'b1; t = cyc; break; end
        end
        chk({nm, "_done_seen"}, ok, 1);
    endtask

    task automatic mon(input int i);
        exp_t   e;
        bit     ok;
        longint t0;
        while (!stop_all) begin
            @(negedge clk);
            if (!mon_en[i] || tx_w[i]) continue;
            t0 = cyc;
            pop(i, e, ok);
            chk($sformatf("dut%0d_expected_frame", i), ok, 1);
            if (!ok) begin
                while (busy_w[i] && !stop_all) @(negedge clk);
                continue;
            end
            for (int b = 0; b < e.nbits; b++) begin
                while (cyc < t0 + b * e.div + e.div / 2) @(negedge clk);
                chk($sformatf("dut%0d_bit%0d", i, b), tx_w[i], e.bits[b]);
                if (b == 0) chk($sformatf("dut%0d_busy_in_frame", i), busy_w[i], 1);
            end
            ok = 1'b0;
            for (int k = 0; k < e.div; k++) begin
                @(negedge clk);
                if (done_w[i]) begin ok = 1'b1; break; end
            end
            chk($sformatf("dut%0d_frame_done_seen", i), ok, 1);
            if (ok) begin
                chk($sformatf("dut%0d_frame_len", i), cyc - t0, e.nbits * e.div - 1);
                chk($sformatf("dut%0d_busy_at_done", i), busy_w[i], 0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin dat[i] = 8'h00; bd[i] = 3'd0; end
        fork
            mon(0); mon(1); mon(2); mon(3);
        join_none
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dut%0d_rst_tx", i), tx_w[i], 1);
            chk($sformatf("dut%0d_rst_busy", i), busy_w[i], 0);
            chk($sformatf("dut%0d_rst_done", i), done_w[i], 0);
        end
        rst = 4'h0;
        repeat (2) @(negedge clk);

        fork
            begin : t_dut0
                longint acc, td;
                int nd, nl;
                // 0x55 @115200: start 0, 1,0,1,0,1,0,1,0, stop 1
                push(0, '{12'h2AA, 10, 434});
                send(0, 8'h55, 3'd4, acc);
                wait_done(0, 5000, "x55", td);
                chk("x55_latency", td - acc, 4340);
                repeat (10) @(negedge clk);

                // abort a frame with reset while a data 0 bit is on the line
                mon_en[0] = 1'b0;
                send(0, 8'h33, 3'd4, acc);
                repeat (2000) @(negedge clk);
                chk("abort_busy_before", busy_w[0], 1);
                chk("abort_line_before", tx_w[0], 0);
                rst[0] = 1'b1;
                #1;
                chk("abort_tx", tx_w[0], 1);
                chk("abort_busy", busy_w[0], 0);
                chk("abort_done", done_w[0], 0);
                @(negedge clk);
                rst[0] = 1'b0;
                nd = 0; nl = 0;
                repeat (4400) begin
                    @(negedge clk);
                    if (done_w[0]) nd++;
                    if (!tx_w[0]) nl++;
                end
                chk("abort_no_done", nd, 0);
                chk("abort_line_idle", nl, 0);
                mon_en[0] = 1'b1;

                // mid-frame request with 0xFF must be ignored, 0xA5 completes
                push(0, '{12'h34A, 10, 434});
                send(0, 8'hA5, 3'd4, acc);
                repeat (2000) @(negedge clk);
                en[0] = 1'b1; dat[0] = 8'hFF; bd[0] = 3'd0;
                @(negedge clk);
                en[0] = 1'b0; dat[0] = 8'h00;
                wait_done(0, 3000, "xA5", td);
                chk("xA5_latency", td - acc, 4340);
                repeat (500) @(negedge clk);
                chk("ignored_busy", busy_w[0], 0);
                chk("ignored_line", tx_w[0], 1);
            end
            begin : t_dut1
                longint acc, td;
                // odd parity of 0x03 is 1
                push(1, '{12'h606, 11, 434});
                send(1, 8'h03, 3'd4, acc);
                wait_done(1, 6000, "odd", td);
                chk("odd_latency", td - acc, 4774);
            end
            begin : t_dut2
                longint acc, td, last_low;
                bit seen;
                // even parity of 0x03 is 0, two stop bits at 9600
                push(2, '{12'hC06, 12, 5208});
                send(2, 8'h03, 3'd0, acc);
                seen = 1'b0; last_low = acc; td = 0;
                for (int k = 0; k < 70000; k++) begin
                    @(negedge clk);
                    if (!tx_w[2]) last_low = cyc;
                    if (done_w[2]) begin seen = 1'b1; td = cyc; break; end
                end
                chk("stop2_done_seen", seen, 1);
                chk("stop2_high_time", td - last_low, 10416);
                chk("stop2_latency", td - acc, 62496);
            end
            begin : t_dut3
                longint d1, d2;
                bit seen;
                // held Send_En, Baud_Set=7 falls back to 9600 (DIV=100 here)
                push(3, '{12'h200, 10, 100});
                push(3, '{12'h302, 10, 100});
                @(negedge clk);
                en[3] = 1'b1; dat[3] = 8'h00; bd[3] = 3'd7;
                seen = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (busy_w[3]) begin seen = 1'b1; break; end
                end
                chk("held_busy_seen", seen, 1);
                dat[3] = 8'h81;
                wait_done(3, 1200, "held1", d1);
                @(negedge clk);
                chk("held_zero_gap", tx_w[3], 0);
                en[3] = 1'b0;
                wait_done(3, 1200, "held2", d2);
                chk("held_done_spacing", d2 - d1, 1000);
                repeat (200) @(negedge clk);
                chk("held_stops", busy_w[3], 0);
            end
        join

        repeat (200) @(negedge clk);
        stop_all = 1'b1;
        for (int i = 0; i < 4; i++) chk($sformatf("dut%0d_queue_drained", i), qsize(i), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
